// File: rtl/audio_i2s_fifo_tx.sv
// I2S transmitter fed from a first-word-fall-through FIFO; BCLK divided down from clk.
// Define AUDIO_I2S_TX_HOLD_ON_UNDERFLOW_EN to repeat the last read frame on underflow.
module audio_i2s_fifo_tx #(
  parameter int unsigned sample_width     = 16,
  parameter int unsigned bclk_div         = 4,
  parameter int unsigned simulation_delay = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      fifo_ren,
  input  logic                      fifo_empty,
  input  logic [2*sample_width-1:0] fifo_dout,
  output logic                      i2s_bclk,
  output logic                      i2s_lrck,
  output logic                      i2s_sdata,
  output logic                      underflow,
  output logic                      busy
);

  localparam int unsigned FrameW = 2 * sample_width;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam int unsigned DivW   = (bclk_div > 1) ? $clog2(bclk_div) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(bclk_div - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(FrameW - 1);
  localparam logic [BitW-1:0] RightPos = BitW'(sample_width);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic                bclk_q, bclk_d;
  logic [FrameW-1:0]   sr_q, sr_d;
  logic [FrameW-1:0]   fill;
  logic                tick, fall, load_step;

  // Register updates carry no modelled delay; the parameter is kept for drop-in compatibility.
  logic unused_sim_delay;
  assign unused_sim_delay = (simulation_delay != 0);

`ifdef AUDIO_I2S_TX_HOLD_ON_UNDERFLOW_EN
  logic [FrameW-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (fifo_ren) last_d = fifo_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end

  assign fill = last_q;
`else
  assign fill = '0;
`endif

  always_comb begin
    tick      = (state_q == StRun) && (div_q == DivLast);
    fall      = tick && bclk_q;
    // Falling step out of k=0 enters k=1: the single frame-load point.
    load_step = fall && (bit_q == '0);
    fifo_ren  = load_step && en && !fifo_empty && !rst;
    underflow = load_step && en && fifo_empty && !rst;
    busy      = (state_q == StRun);
    i2s_bclk  = bclk_q;
    i2s_lrck  = (state_q == StRun) && (bit_q >= RightPos);
    i2s_sdata = sr_q[FrameW-1];
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    bclk_d  = bclk_q;
    sr_d    = sr_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StRun;
      end
      StRun: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) bclk_d = ~bclk_q;
        if (fall) begin
          bit_d = (bit_q == BitLast) ? '0 : bit_q + 1'b1;
          if (load_step) begin
            if (!en) begin
              state_d = StIdle;
              div_d   = '0;
              bit_d   = '0;
              bclk_d  = 1'b0;
              sr_d    = '0;
            end else if (!fifo_empty) begin
              sr_d = fifo_dout;
            end else begin
              sr_d = fill;
            end
          end else begin
            sr_d = {sr_q[FrameW-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: doc/audio_i2s_fifo_tx.md
# audio_i2s_fifo_tx

Read-side consumer for the audio sample FIFO: pulls stereo sample words from a first-word-fall-through FIFO and serialises them as a standard I2S stream (BCLK, LRCK, SDATA) with a BCLK generated by dividing the system clock. Sits on the read clock domain of the audio player, directly after the FWFT FIFO, and drives the DAC pins. Handles FIFO underflow without breaking frame timing.

## Interface
- sample_width, 16: bits per channel sample (W); valid range 8..32.
- bclk_div, 4: clk cycles per BCLK half-period (D); ≥1.
- simulation_delay, 1: register update delay for simulation.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  level enable; start/stop only at frame boundaries.
- fifo_ren  output  1  FIFO READ enable; one-cycle pulse, FWFT semantics.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  2W  frame word {left[2W-1:W], right[W-1:0]}; valid while !fifo_empty.
- i2s_bclk  output  1  bit clock, idle low.
- i2s_lrck  output  1  word select: 0 = left, 1 = right.
- i2s_sdata  output  1  serial data, MSB first, changes on BCLK falling edge.
- underflow  output  1  one-cycle pulse: frame loaded while FIFO empty.
- busy  output  1  high in RUN state.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: bclk=0, lrck=0, sdata=0, busy=0, counters cleared. en=1 → RUN next cycle with bit_cnt=0, div_cnt=0.
- RUN: div_cnt counts 0..D-1; at D-1 it wraps and i2s_bclk toggles. A 1→0 toggle is a "falling step"; bit_cnt (0..2W-1, wraps) advances on each falling step.
- Frame position k = bit_cnt. lrck = 0 for k in 0..W-1, 1 for k in W..2W-1.
- Shift register sr (2W bits), sdata = sr MSB. On the falling step entering k=1: load sr. On every other falling step: shift sr left, fill 0.
- Result: left MSB at k=1, left LSB at k=W, right MSB at k=W+1, right LSB at k=0 of the next frame (standard I2S one-bit delay).
- Load: if fifo_empty=0 → sr ← fifo_dout, fifo_ren=1 that cycle. If fifo_empty=1 → underflow=1 that cycle, fifo_ren=0, sr ← underflow fill (see Configuration).
- fifo_ren is combinational from registered state (load step) and fifo_empty; never asserted while empty, never asserted in IDLE.
- Stop: at the falling step entering k=1 with en=0 → no load, no fifo_ren, go to IDLE (outputs to idle values on that edge). The right LSB of the last frame has therefore been fully driven.
- en toggling mid-frame has no effect until the next k=1 boundary.

## Timing
- IDLE→RUN: 1 cycle after en sampled high.
- First BCLK rising edge D cycles after entering RUN; first load (first fifo_ren) 2D cycles after entering RUN.
- BCLK period 2D clk; frame 2W BCLK = 4·W·D clk; exactly one load per frame.
- sdata, lrck change only in the cycle bclk goes 1→0; stable across the rising edge.
- rst mid-operation: all outputs to reset values on the next clk edge; any partially sent frame discarded; no fifo_ren in or after the reset cycle until a new RUN.
- rst has priority over en.

## Configuration
- AUDIO_I2S_TX_HOLD_ON_UNDERFLOW_EN defined: underflow load reuses the last successfully read frame word (zero if none since reset).
- Not defined: underflow load uses all-zero word (silence).
- underflow pulse and fifo_ren behaviour identical in both builds.

## Test plan
- W=16, D=2, FIFO holds 0xA5A5_3C3C, en=1 → fifo_ren single pulse 4 clk after RUN entry; sdata bits k=1..16 = 0xA5A5, k=17..31,0 = 0x3C3C; lrck low k=0..15.
- Back-to-back 3 frames 0x0001_8000, 0xFFFF_0000, 0x1234_5678 → exactly 3 fifo_ren pulses 128 clk apart, no gaps, bitstream matches.
- FIFO empty after 0x1111_2222 → underflow pulse at next load; next frame = 0x1111_2222 with macro, 0x0000_0000 without; fifo_ren stays 0.
- en dropped at k=20 → frame completes, IDLE entered at the next k=1 step, no further fifo_ren; bclk/lrck/sdata = 0.
- rst pulsed at k=9 of a frame → next edge all outputs 0, busy=0; en still 1 → restart, first fifo_ren 2D+1 cycles after rst release.
- D=1, W=8 → bclk toggles every clk, frame = 32 clk, one fifo_ren per 32 clk.
